fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core, directly upstream of decode. Decode contains the immediate extender, which consumes `id_instr` from this block.
- Generates the PC and runs a request/acknowledge handshake with an instruction memory of variable latency.
- Presents registered instruction, PC and PC+4 to the IF/ID boundary.
- Handles decode stalls with a one-entry skid buffer, and handles branch/jump redirects, including draining any memory access already in flight.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with skid buffer and redirect drain
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] idpc_q;
  logic [31:0] idp4_q;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        xfer;
  logic        accept;
  logic [31:0] target;

  // The address register diverges from pc_q only while draining a stale fetch.
  assign xfer        = req_q && imem_ack;
  assign accept      = !valid_q || !stall;
  assign target      = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = idpc_q;
  assign id_pc_plus4 = idp4_q;

  // Fetch FSM: PC, memory handshake, IF/ID register and skid buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      idpc_q     <= 32'h0;
      idp4_q     <= 32'h0;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0;
    end else if (redirect) begin
      // Flush everything younger than the branch; a pending request must
      // still complete at its original address before the target is issued.
      pc_q       <= target;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      skid_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (xfer) begin
            addr_q <= target;
          end else begin
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer) begin
            state  <= FETCH;
            addr_q <= target;
          end
        end
        default: begin
          state  <= FETCH;
          addr_q <= target;
          req_q  <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          addr_q <= pc_q;
        end
        FETCH: begin
          if (xfer) begin
            if (accept) begin
              valid_q <= 1'b1;
              instr_q <= imem_rdata;
              idpc_q  <= pc_q;
              idp4_q  <= pc_q + 32'd4;
            end else begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= pc_q;
              state      <= HOLD;
              req_q      <= 1'b0;
            end
            pc_q   <= pc_q + 32'd4;
            addr_q <= pc_q + 32'd4;
          end else if (accept) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_q    <= skid_valid;
            instr_q    <= skid_instr;
            idpc_q     <= skid_pc;
            idp4_q     <= skid_pc + 32'd4;
            skid_valid <= 1'b0;
            state      <= FETCH;
            req_q      <= 1'b1;
          end
        end
        DRAIN: begin
          if (xfer) begin
            addr_q <= pc_q;
            state  <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] XOR_KEY   = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int          compared;
  int          mismatched;
  int          mem_lat;
  int          wait_cnt;
  logic        force_ack;
  logic [31:0] exp_pc;
  int          nvalid;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after mem_lat extra wait cycles; rdata is a function of the address.
  assign imem_ack   = force_ack || (imem_req && (wait_cnt >= mem_lat));
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : (imem_addr ^ XOR_KEY);

  always_ff @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    compared++;
    assert (obs === req_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req_v);
    end
  endtask

  // One clock: drive inputs, sample just before the edge, update the
  // in-order instruction-stream model, then check the post-edge state.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic        p_valid, p_req, p_ack, p_rst;
    logic [31:0] p_pc, p_instr, p_p4, p_addr;
    stall = st; redirect = rd; redirect_pc = rpc;
    @(negedge clk);
    p_valid = id_valid; p_req = imem_req; p_ack = imem_ack; p_rst = rst_n;
    p_pc = id_pc; p_instr = id_instr; p_p4 = id_pc_plus4; p_addr = imem_addr;
    @(posedge clk);
    #1;
    if (!p_rst) begin
      exp_pc = RESET_PC;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", id_valid, 0);
      chk("rst_instr", id_instr, NOP_INSTR);
      chk("rst_pc", id_pc, 0);
      chk("rst_pc4", id_pc_plus4, 0);
    end else begin
      if (p_valid && !st && !rd) begin
        chk("stream_pc", p_pc, exp_pc);
        chk("stream_instr", p_instr, exp_pc ^ XOR_KEY);
        chk("stream_pc4", p_p4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
      if (rd) begin
        exp_pc = rpc & 32'hFFFF_FFFC;
        chk("flush_valid", id_valid, 0);
      end
      if (p_req && !p_ack) begin
        chk("req_stable", imem_req, 1);
        chk("addr_stable", imem_addr, p_addr);
      end
    end
    if (!id_valid) chk("nop_when_empty", id_instr, NOP_INSTR);
    chk("addr_align", {30'd0, imem_addr[1:0]}, 0);
  endtask

  initial begin
    compared = 0; mismatched = 0; mem_lat = 0; force_ack = 1'b0; exp_pc = RESET_PC;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset, then zero-wait streaming.
    step(0, 0, 0); step(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("first_valid_c1", id_valid, 0);
    step(0, 0, 0);
    chk("first_valid_c2", id_valid, 1);
    chk("first_pc", id_pc, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      chk("zw_throughput", id_valid, 1);
    end

    // Three-cycle ack latency: one instruction every three cycles.
    mem_lat = 2; nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0);
      if (id_valid) nvalid++;
    end
    chk("lat3_count", nvalid, 3);

    // Stall with an ack arriving while id_pc=8 is held.
    rst_n = 1'b0; mem_lat = 0; step(0, 0, 0); rst_n = 1'b1;
    for (int i = 0; i < 20 && !(id_valid && id_pc == 32'h8); i++) step(0, 0, 0);
    chk("reach_pc8", id_pc, 32'h8);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("stall_valid", id_valid, 1);
      chk("stall_pc", id_pc, 32'h8);
      chk("hold_req", imem_req, 0);
    end
    step(0, 0, 0);
    chk("unstall_pc_c", id_pc, 32'hC);
    step(0, 0, 0);
    chk("unstall_pc_10", id_pc, 32'h10);

    // Redirect while the fetch of 0x20 is pending.
    mem_lat = 2;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h20 && !imem_ack); i++) step(0, 0, 0);
    chk("pending_20", imem_addr, 32'h20);
    step(0, 1, 32'h100);
    chk("drain_addr", imem_addr, 32'h20);
    chk("drain_req", imem_req, 1);
    for (int i = 0; i < 20 && !id_valid; i++) step(0, 0, 0);
    chk("post_drain_pc", id_pc, 32'h100);

    // Redirect coincident with an ack, then while stalled in HOLD.
    mem_lat = 0;
    step(0, 0, 0);
    chk("coincide_ack", imem_ack, 1);
    step(0, 1, 32'h203);
    chk("coincide_addr", imem_addr, 32'h200);
    step(0, 0, 0);
    chk("coincide_pc", id_pc, 32'h200);
    step(1, 0, 0);
    chk("hold_entry_req", imem_req, 0);
    step(1, 1, 32'h203);
    chk("hold_redir_valid", id_valid, 0);
    step(1, 0, 0);
    chk("hold_redir_pc", id_pc, 32'h200);
    step(0, 0, 0);

    // Reset while waiting, followed by a late ack.
    mem_lat = 3;
    step(0, 0, 0);
    chk("waiting", imem_req && !imem_ack, 1);
    rst_n = 1'b0; force_ack = 1'b1;
    step(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("late_ack_valid", id_valid, 0);
    chk("late_ack_instr", id_instr, NOP_INSTR);
    force_ack = 1'b0; mem_lat = 0;
    step(0, 0, 0);
    chk("restart_pc", id_pc, RESET_PC);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc_plus4, 32'h0);
    step(0, 0, 0);
    chk("wrap_next", id_pc, 32'h0);

    // Randomized traffic against the stream model.
    for (int i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(0, 3);
      rst_n = ($urandom_range(0, 99) != 0);
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom);
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
